i2s_tx_sched: RTL

Frame scheduler and sample-feed controller for the I2S transmit serializer. It generates the free-running `lrclk` word-select and keeps its bit count aligned with the serializer's. It pulls stereo samples from an upstream source over a valid/ready handshake and presents stable `left_chan`/`right_chan` words ahead of the serializer's frame latch point. It also handles start/stop sequencing and underruns.

---
 rtl/i2s_tx_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/i2s_tx_sched.sv
// I2S transmit frame scheduler: lrclk generation, sample staging and start/stop/underrun control.
// Optional build macro I2S_TX_SCHED_HOLD_EN repeats the last sample on underrun instead of muting.
module i2s_tx_sched #(
    parameter int unsigned BITSIZE = 32
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               enable,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BITSIZE-1:0] s_left,
    input  logic [BITSIZE-1:0] s_right,
    output logic               lrclk,
    output logic [BITSIZE-1:0] left_chan,
    output logic [BITSIZE-1:0] right_chan,
    output logic               frame_start,
    output logic               running,
    output logic [15:0]        underrun_cnt
);

    localparam int unsigned CW = $clog2(BITSIZE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITSIZE);
    localparam logic [CW-1:0] CNT_PRE  = CW'(BITSIZE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               lrclk_q, lrclk_d;
    logic [BITSIZE-1:0] left_q, left_d, right_q, right_d;
    logic [BITSIZE-1:0] stage_l_q, stage_l_d, stage_r_q, stage_r_d;
    logic               stage_full_q, stage_full_d;
    logic               fs_q, fs_d;
    logic [15:0]        urun_q, urun_d;
    logic               ev_b, ev_l, hs;

    assign ev_b = (cnt_q == CNT_LAST) && lrclk_q;
    assign ev_l = (cnt_q == CNT_PRE) && lrclk_q;
    assign s_ready = ((state_q == ARM) || (state_q == RUN)) && !stage_full_q;
    assign hs = s_valid && s_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == CNT_LAST) ? CNT_ONE : cnt_q + CNT_ONE;
        lrclk_d      = (cnt_q == CNT_LAST) ? ~lrclk_q : lrclk_q;
        left_d       = left_q;
        right_d      = right_q;
        stage_l_d    = stage_l_q;
        stage_r_d    = stage_r_q;
        stage_full_d = stage_full_q;
        fs_d         = ev_b;
        urun_d       = urun_q;

        // A handshake only fills an empty stage, so it never collides with a consume at L.
        if (hs) begin
            stage_l_d    = s_left;
            stage_r_d    = s_right;
            stage_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ev_l) begin
                    left_d  = '0;
                    right_d = '0;
                end
                if (enable) state_d = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_d      = IDLE;
                    stage_full_d = 1'b0;
                    if (ev_l) begin
                        left_d  = '0;
                        right_d = '0;
                    end
                end else if (ev_l) begin
                    if (stage_full_q) begin
                        left_d       = stage_l_q;
                        right_d      = stage_r_q;
                        stage_full_d = 1'b0;
                        state_d      = RUN;
                    end else begin
                        left_d  = '0;
                        right_d = '0;
                    end
                end
            end
            RUN: begin
                if (ev_l) begin
                    if (stage_full_q) begin
                        left_d       = stage_l_q;
                        right_d      = stage_r_q;
                        stage_full_d = 1'b0;
                    end else begin
                        if (urun_q != 16'hFFFF) urun_d = urun_q + 16'd1;
`ifdef I2S_TX_SCHED_HOLD_EN
`else
                        left_d  = '0;
                        right_d = '0;
`endif
                    end
                end
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (ev_b) begin
                    state_d      = IDLE;
                    stage_full_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge sclk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ONE;
            lrclk_q      <= 1'b1;
            left_q       <= '0;
            right_q      <= '0;
            stage_l_q    <= '0;
            stage_r_q    <= '0;
            stage_full_q <= 1'b0;
            fs_q         <= 1'b0;
            urun_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lrclk_q      <= lrclk_d;
            left_q       <= left_d;
            right_q      <= right_d;
            stage_l_q    <= stage_l_d;
            stage_r_q    <= stage_r_d;
            stage_full_q <= stage_full_d;
            fs_q         <= fs_d;
            urun_q       <= urun_d;
        end
    end

    assign lrclk        = lrclk_q;
    assign left_chan    = left_q;
    assign right_chan   = right_q;
    assign frame_start  = fs_q;
    assign running      = (state_q == RUN);
    assign underrun_cnt = urun_q;

endmodule
